// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data SRAM request/address-ok/data-ok bus between mem_stage and memory
// master: data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata out; data_addr_ok, data_data_ok, data_rdata in
// slave:  mirror image of master
interface mem_stage_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wstrb,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wstrb,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with data SRAM handshake and MEM/WB register
// clk, rst           : clock, synchronous active-high reset
// mem_*              : registered EX/MEM bundle (held stable by upstream while mem_stall=1)
// dbus (master)      : data SRAM request/address-ok/data-ok bus
// mem_stall          : hold EX/MEM and upstream while an access is outstanding
// wb_*               : MEM/WB register feeding write-back and forwarding
module mem_stage (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_valid,
    input  logic               mem_ref_we,
    input  logic [4:0]         mem_rd,
    input  logic [31:0]        mem_alu_result,
    input  logic               mem_dram_re,
    input  logic               mem_dram_we,
    input  logic               mem_res_from_dram,
    input  logic [31:0]        mem_dram_waddr,
    input  logic [31:0]        mem_dram_wdata,
    input  logic [2:0]         mem_op,
    input  logic [31:0]        mem_pc,
    mem_stage_if.master        dbus,
    output logic               mem_stall,
    output logic               wb_valid,
    output logic               wb_ref_we,
    output logic [4:0]         wb_rd,
    output logic [31:0]        wb_wdata,
    output logic [31:0]        wb_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;

    logic        access;
    logic        resp_done;
    logic [31:0] addr_raw;
    logic [3:0]  store_strb;
    logic [31:0] store_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    assign access    = mem_valid & (mem_dram_re | mem_dram_we);
    // data_ok only counts once the request has been accepted
    assign resp_done = (state == RESP) & dbus.data_data_ok;
    assign mem_stall = access & ~resp_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        dbus.data_req = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    dbus.data_req = 1'b1;
                    state_next    = dbus.data_addr_ok ? RESP : REQ;
                end
            end
            REQ: begin
                dbus.data_req = 1'b1;
                if (dbus.data_addr_ok) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (dbus.data_data_ok) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // No request may leave the stage while reset is held, whatever the state register says
        if (rst) begin
            dbus.data_req = 1'b0;
        end
    end

    assign addr_raw = mem_dram_we ? mem_dram_waddr : mem_alu_result;

    always_comb begin
        case (mem_op[1:0])
            2'd0:    dbus.data_addr = addr_raw;
            2'd1:    dbus.data_addr = {addr_raw[31:1], 1'b0};
            default: dbus.data_addr = {addr_raw[31:2], 2'b00};
        endcase
    end

    assign dbus.data_wr   = mem_dram_we;
    assign dbus.data_size = mem_op[1:0];

    always_comb begin
        store_strb = 4'b1111;
        store_data = mem_dram_wdata;
        case (mem_op[1:0])
            2'd0: begin
                store_strb = 4'b0001 << addr_raw[1:0];
                store_data = {4{mem_dram_wdata[7:0]}};
            end
            2'd1: begin
                store_strb = addr_raw[1] ? 4'b1100 : 4'b0011;
                store_data = {2{mem_dram_wdata[15:0]}};
            end
            default: begin
                store_strb = 4'b1111;
                store_data = mem_dram_wdata;
            end
        endcase
    end

    assign dbus.data_wstrb = mem_dram_we ? store_strb : 4'b0000;
    assign dbus.data_wdata = store_data;

    always_comb begin
        case (addr_raw[1:0])
            2'd0:    ld_byte = dbus.data_rdata[7:0];
            2'd1:    ld_byte = dbus.data_rdata[15:8];
            2'd2:    ld_byte = dbus.data_rdata[23:16];
            default: ld_byte = dbus.data_rdata[31:24];
        endcase
        ld_half = addr_raw[1] ? dbus.data_rdata[31:16] : dbus.data_rdata[15:0];
        case (mem_op[1:0])
            2'd0:    load_data = mem_op[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'd1:    load_data = mem_op[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_data = dbus.data_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid  <= 1'b0;
            wb_ref_we <= 1'b0;
            wb_rd     <= 5'd0;
            wb_wdata  <= 32'd0;
            wb_pc     <= 32'd0;
        end else if (mem_stall | ~mem_valid) begin
            wb_valid  <= 1'b0;
            wb_ref_we <= 1'b0;
        end else begin
            wb_valid  <= 1'b1;
            wb_ref_we <= mem_ref_we;
            wb_rd     <= mem_rd;
            wb_pc     <= mem_pc;
            wb_wdata  <= mem_res_from_dram ? load_data : mem_alu_result;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed scoreboard bench for mem_stage
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_ref_we;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu_result;
    logic        mem_dram_re;
    logic        mem_dram_we;
    logic        mem_res_from_dram;
    logic [31:0] mem_dram_waddr;
    logic [31:0] mem_dram_wdata;
    logic [2:0]  mem_op;
    logic [31:0] mem_pc;
    logic        mem_stall;
    logic        wb_valid;
    logic        wb_ref_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wdata;
    logic [31:0] wb_pc;

    mem_stage_if dbus ();

    mem_stage dut (
        .clk               (clk),
        .rst               (rst),
        .mem_valid         (mem_valid),
        .mem_ref_we        (mem_ref_we),
        .mem_rd            (mem_rd),
        .mem_alu_result    (mem_alu_result),
        .mem_dram_re       (mem_dram_re),
        .mem_dram_we       (mem_dram_we),
        .mem_res_from_dram (mem_res_from_dram),
        .mem_dram_waddr    (mem_dram_waddr),
        .mem_dram_wdata    (mem_dram_wdata),
        .mem_op            (mem_op),
        .mem_pc            (mem_pc),
        .dbus              (dbus),
        .mem_stall         (mem_stall),
        .wb_valid          (wb_valid),
        .wb_ref_we         (wb_ref_we),
        .wb_rd             (wb_rd),
        .wb_wdata          (wb_wdata),
        .wb_pc             (wb_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ref_we;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [31:0] pc;
    } wb_exp_t;

    wb_exp_t sb[$];
    int      errors = 0;
    int      checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        wb_exp_t e;
        @(posedge clk);
        #1;
        if (wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("wb_spurious", 32'(wb_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_wdata", wb_wdata, e.wdata);
                chk("wb_pc", wb_pc, e.pc);
                chk("wb_ref_we", 32'(wb_ref_we), 32'(e.ref_we));
            end
        end
    endtask

    task automatic expect_bubble(input string tag);
        chk(tag, 32'(wb_valid), 32'd0);
    endtask

    task automatic set_idle();
        mem_valid         = 1'b0;
        mem_ref_we        = 1'b0;
        mem_rd            = 5'd0;
        mem_alu_result    = 32'd0;
        mem_dram_re       = 1'b0;
        mem_dram_we       = 1'b0;
        mem_res_from_dram = 1'b0;
        mem_dram_waddr    = 32'd0;
        mem_dram_wdata    = 32'd0;
        mem_op            = 3'd0;
        mem_pc            = 32'd0;
    endtask

    task automatic drive(input logic ref_we, input logic [4:0] rd, input logic [31:0] alu,
                         input logic re, input logic we, input logic from_dram,
                         input logic [31:0] waddr, input logic [31:0] wdata,
                         input logic [2:0] op, input logic [31:0] pc);
        mem_valid         = 1'b1;
        mem_ref_we        = ref_we;
        mem_rd            = rd;
        mem_alu_result    = alu;
        mem_dram_re       = re;
        mem_dram_we       = we;
        mem_res_from_dram = from_dram;
        mem_dram_waddr    = waddr;
        mem_dram_wdata    = wdata;
        mem_op            = op;
        mem_pc            = pc;
    endtask

    // Zero-wait load: addr_ok with the request, data_ok the next cycle
    task automatic do_load(input logic [31:0] addr, input logic [2:0] op, input logic [31:0] rdata,
                           input logic [4:0] rd, input logic [31:0] exp_addr,
                           input logic [31:0] exp_data, input logic [31:0] pc);
        drive(1'b1, rd, addr, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0, op, pc);
        sb.push_back('{ref_we: 1'b1, rd: rd, wdata: exp_data, pc: pc});
        dbus.data_addr_ok = 1'b1;
        #1;
        chk("ld_req", 32'(dbus.data_req), 32'd1);
        chk("ld_wr", 32'(dbus.data_wr), 32'd0);
        chk("ld_addr", dbus.data_addr, exp_addr);
        chk("ld_wstrb", 32'(dbus.data_wstrb), 32'd0);
        chk("ld_stall1", 32'(mem_stall), 32'd1);
        tick();
        expect_bubble("ld_bubble");
        dbus.data_addr_ok = 1'b0;
        dbus.data_data_ok = 1'b1;
        dbus.data_rdata   = rdata;
        #1;
        chk("ld_stall2", 32'(mem_stall), 32'd0);
        chk("ld_req2", 32'(dbus.data_req), 32'd0);
        tick();
        dbus.data_data_ok = 1'b0;
        set_idle();
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] op,
                            input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata, input logic [31:0] pc);
        drive(1'b0, 5'd0, addr, 1'b0, 1'b1, 1'b0, addr, data, op, pc);
        sb.push_back('{ref_we: 1'b0, rd: 5'd0, wdata: addr, pc: pc});
        dbus.data_addr_ok = 1'b1;
        #1;
        chk("st_req", 32'(dbus.data_req), 32'd1);
        chk("st_wr", 32'(dbus.data_wr), 32'd1);
        chk("st_addr", dbus.data_addr, exp_addr);
        chk("st_wstrb", 32'(dbus.data_wstrb), 32'(exp_strb));
        chk("st_wdata", dbus.data_wdata, exp_wdata);
        chk("st_size", 32'(dbus.data_size), 32'(op[1:0]));
        tick();
        expect_bubble("st_bubble");
        dbus.data_addr_ok = 1'b0;
        dbus.data_data_ok = 1'b1;
        #1;
        chk("st_stall2", 32'(mem_stall), 32'd0);
        tick();
        dbus.data_data_ok = 1'b0;
        set_idle();
    endtask

    int stalls;

    initial begin
        rst               = 1'b1;
        dbus.data_addr_ok = 1'b0;
        dbus.data_data_ok = 1'b0;
        dbus.data_rdata   = 32'd0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_ref_we", 32'(wb_ref_we), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_wdata", wb_wdata, 32'd0);
        chk("rst_wb_pc", wb_pc, 32'd0);
        chk("rst_data_req", 32'(dbus.data_req), 32'd0);
        rst = 1'b0;

        // ALU op passes through in one cycle
        drive(1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd2, 32'h0000_1000);
        sb.push_back('{ref_we: 1'b1, rd: 5'd5, wdata: 32'h0000_1234, pc: 32'h0000_1000});
        #1;
        chk("alu_req", 32'(dbus.data_req), 32'd0);
        chk("alu_stall", 32'(mem_stall), 32'd0);
        tick();
        set_idle();
        tick();
        expect_bubble("idle_bubble");

        // Loads, issued back to back
        do_load(32'h0000_0100, 3'd2, 32'hDEAD_BEEF, 5'd7,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_1004);
        do_load(32'h0000_0103, 3'd0, 32'h80FF_FFFF, 5'd8,  32'h0000_0103, 32'hFFFF_FF80, 32'h0000_1008);
        do_load(32'h0000_0103, 3'd4, 32'h80FF_FFFF, 5'd9,  32'h0000_0103, 32'h0000_0080, 32'h0000_100C);
        do_load(32'h0000_0101, 3'd0, 32'h0000_7F00, 5'd10, 32'h0000_0101, 32'h0000_007F, 32'h0000_1010);
        do_load(32'h0000_0102, 3'd5, 32'hBEEF_0000, 5'd11, 32'h0000_0102, 32'h0000_BEEF, 32'h0000_1014);
        do_load(32'h0000_0101, 3'd1, 32'h1234_8765, 5'd12, 32'h0000_0100, 32'hFFFF_8765, 32'h0000_1018);

        // Stores
        do_store(32'h0000_0202, 32'h0000_ABCD, 3'd1, 32'h0000_0202, 4'b1100, 32'hABCD_ABCD, 32'h0000_1020);
        do_store(32'h0000_0201, 32'h0000_1357, 3'd1, 32'h0000_0200, 4'b0011, 32'h1357_1357, 32'h0000_1024);
        do_store(32'h0000_0301, 32'h1234_5678, 3'd0, 32'h0000_0301, 4'b0010, 32'h7878_7878, 32'h0000_1028);
        do_store(32'h0000_0403, 32'hA5A5_5A5A, 3'd2, 32'h0000_0400, 4'b1111, 32'hA5A5_5A5A, 32'h0000_102C);

        // Load with addr_ok two cycles late and data_ok three cycles late
        drive(1'b1, 5'd13, 32'h0000_0500, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 3'd2, 32'h0000_1030);
        sb.push_back('{ref_we: 1'b1, rd: 5'd13, wdata: 32'hCAFE_F00D, pc: 32'h0000_1030});
        stalls = 0;
        for (int i = 0; i < 7; i++) begin
            dbus.data_addr_ok = (i == 2);
            // data_ok at i==1 arrives while still in REQ and must be ignored
            dbus.data_data_ok = (i == 1) || (i == 6);
            dbus.data_rdata   = (i == 6) ? 32'hCAFE_F00D : 32'h0BAD_BAD0;
            #1;
            chk("dly_req", 32'(dbus.data_req), 32'(i <= 2));
            if (mem_stall === 1'b1) stalls++;
            tick();
            if (i < 6) expect_bubble("dly_bubble");
        end
        chk("dly_stall_cycles", 32'(stalls), 32'd6);
        dbus.data_addr_ok = 1'b0;
        dbus.data_data_ok = 1'b0;
        set_idle();

        // Reset while in REQ: no request may be driven during rst
        drive(1'b1, 5'd14, 32'h0000_0600, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 3'd2, 32'h0000_1040);
        #1;
        tick();
        expect_bubble("req_bubble");
        rst = 1'b1;
        #1;
        chk("rst_req_gated", 32'(dbus.data_req), 32'd0);
        tick();
        expect_bubble("rst_req_wb");
        rst = 1'b0;

        // Same load reissued, accepted, then reset in RESP
        dbus.data_addr_ok = 1'b1;
        #1;
        chk("reissue_req", 32'(dbus.data_req), 32'd1);
        tick();
        dbus.data_addr_ok = 1'b0;
        rst = 1'b1;
        set_idle();
        tick();
        expect_bubble("rst_resp_wb");
        rst = 1'b0;
        dbus.data_data_ok = 1'b1;
        dbus.data_rdata   = 32'h5555_AAAA;
        #1;
        chk("stale_req", 32'(dbus.data_req), 32'd0);
        tick();
        expect_bubble("stale_ignored");

        // FSM must be back in IDLE: a stray data_ok alongside a fresh request is ignored
        drive(1'b1, 5'd15, 32'h0000_0700, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 3'd2, 32'h0000_1050);
        sb.push_back('{ref_we: 1'b1, rd: 5'd15, wdata: 32'h1357_9BDF, pc: 32'h0000_1050});
        dbus.data_addr_ok = 1'b1;
        dbus.data_data_ok = 1'b1;
        #1;
        chk("post_rst_req", 32'(dbus.data_req), 32'd1);
        chk("post_rst_stall", 32'(mem_stall), 32'd1);
        tick();
        expect_bubble("post_rst_bubble");
        dbus.data_addr_ok = 1'b0;
        dbus.data_rdata   = 32'h1357_9BDF;
        #1;
        chk("post_rst_stall2", 32'(mem_stall), 32'd0);
        tick();
        dbus.data_data_ok = 1'b0;
        set_idle();
        tick();
        expect_bubble("final_bubble");

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
